// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry, move opcodes, controller states and row-full helper.
// Board cell (r,c) lives at bit r*COLS+c; row 0 is the top row.
package tetris_pkg;
    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef enum logic [2:0] {
        OP_NONE    = 3'd0,
        OP_ROT_CW  = 3'd1,
        OP_ROT_CCW = 3'd2,
        OP_LEFT    = 3'd3,
        OP_RIGHT   = 3'd4,
        OP_DOWN    = 3'd5
    } move_op_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR_ALL,
        S_SPAWN,
        S_SPWAIT,
        S_PLAY,
        S_REQ,
        S_WAIT,
        S_LOCK,
        S_SCAN,
        S_SHIFT,
        S_GAME_OVER
    } state_t;

    function automatic logic row_full(input logic [ROWS*COLS-1:0] board, input logic [$clog2(ROWS)-1:0] idx);
        return &board[idx*COLS +: COLS];
    endfunction
endpackage

// File: rtl/tetris_line_clear.sv
// tetris_line_clear: settled-board register with piece merge, bottom-up row scan,
// one-row-per-cycle collapse and saturating cleared-lines counter.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   i_clr_all         clear board and line counter
//   i_lock            merge i_piece_mask into the board, point scan at the bottom row
//   i_scan_dec        move scan index one row up
//   i_shift           collapse rows 0..index down by one, count a cleared line
//   i_piece_mask      active piece cells
//   o_board_q         settled board
//   o_lines           cleared-lines count
//   o_row_is_full     scanned row is completely occupied
//   o_done_scan       scan index is at row 0
module tetris_line_clear
    import tetris_pkg::*;
#(
    parameter int LINES_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr_all,
    input  logic                 i_lock,
    input  logic                 i_scan_dec,
    input  logic                 i_shift,
    input  logic [ROWS*COLS-1:0] i_piece_mask,
    output logic [ROWS*COLS-1:0] o_board_q,
    output logic [LINES_W-1:0]   o_lines,
    output logic                 o_row_is_full,
    output logic                 o_done_scan
);
    localparam int IW = $clog2(ROWS);

    logic [ROWS*COLS-1:0] r_board;
    logic [ROWS*COLS-1:0] w_shifted;
    logic [IW-1:0]        r_idx;
    logic [LINES_W-1:0]   r_lines;

    // Rows above the full one slide down; rows below it are untouched.
    always_comb begin
        w_shifted = r_board;
        for (int r = 0; r < ROWS; r++)
            if (r == 0)
                w_shifted[0 +: COLS] = '0;
            else if (r <= int'(r_idx))
                w_shifted[r*COLS +: COLS] = r_board[(r-1)*COLS +: COLS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_board <= '0;
            r_idx   <= '0;
            r_lines <= '0;
        end else if (i_clr_all) begin
            r_board <= '0;
            r_lines <= '0;
        end else if (i_lock) begin
            r_board <= r_board | i_piece_mask;
            r_idx   <= IW'(ROWS-1);
        end else if (i_shift) begin
            r_board <= w_shifted;
            r_lines <= r_lines + LINES_W'(~&r_lines);
        end else if (i_scan_dec) begin
            r_idx <= r_idx - 1'b1;
        end
    end

    assign o_board_q     = r_board;
    assign o_lines       = r_lines;
    assign o_row_is_full = row_full(r_board, r_idx);
    assign o_done_scan   = (r_idx == '0);
endmodule

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: move sequencer for the Tetris board datapath.
// Edge-detects buttons and gravity, issues one move request at a time, locks the
// piece on a failed gravity move, clears full rows, spawns and detects game over.
// Board geometry (ROWS, COLS) comes from tetris_pkg.
// Optional macro TETRIS_HARD_DROP_EN adds input hard_drop (repeated DOWN until blocked).
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start                       leave IDLE / GAME_OVER
//   rotate, rotate_direction    rotate button, 1 = cw
//   left, right, ticker         move buttons, gravity pulse (levels)
//   mv_valid, mv_op             one-cycle move request and opcode
//   mv_done, mv_ok              datapath verdict
//   piece_mask                  active piece cells
//   spawn_req, spawn_done, spawn_collide   spawn handshake
//   board_q, lines, game_over   settled board, cleared rows, end of game
module tetris_game_ctrl
    import tetris_pkg::*;
#(
    parameter int LINES_W    = 16,
    parameter int MV_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 rotate,
    input  logic                 rotate_direction,
    input  logic                 left,
    input  logic                 right,
    input  logic                 ticker,
`ifdef TETRIS_HARD_DROP_EN
    input  logic                 hard_drop,
`endif
    output logic                 mv_valid,
    output logic [2:0]           mv_op,
    input  logic                 mv_done,
    input  logic                 mv_ok,
    input  logic [ROWS*COLS-1:0] piece_mask,
    output logic                 spawn_req,
    input  logic                 spawn_done,
    input  logic                 spawn_collide,
    output logic [ROWS*COLS-1:0] board_q,
    output logic [LINES_W-1:0]   lines,
    output logic                 game_over
);
    localparam int TW = $clog2(MV_TIMEOUT+1);

    state_t   r_state, w_next;
    move_op_t r_op, w_op;
    logic     r_rot_d, r_l_d, r_r_d, r_dn_d;
    logic     r_pend_rot, r_pend_l, r_pend_r, r_pend_dn, r_rot_dir;
    logic [TW-1:0] r_tmo;
    logic     w_acc, w_play, w_issue;
    logic     w_rot_e, w_clr_rot, w_clr_l, w_clr_r, w_clr_dn;
    logic     w_hd_pend, w_hd_act, w_clr_hd;
    logic     w_row_full, w_done_scan;

    assign w_acc   = (r_state == S_PLAY) || (r_state == S_WAIT) || (r_state == S_REQ);
    assign w_play  = (r_state == S_PLAY);
    assign w_rot_e = rotate & ~r_rot_d & w_acc;

`ifdef TETRIS_HARD_DROP_EN
    logic r_hd_d, r_pend_hd, r_hd_act;
    assign w_hd_pend = r_pend_hd;
    assign w_hd_act  = r_hd_act;
    assign w_clr_hd  = w_play & r_pend_hd;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hd_d    <= 1'b0;
            r_pend_hd <= 1'b0;
            r_hd_act  <= 1'b0;
        end else begin
            r_hd_d    <= hard_drop;
            r_pend_hd <= (r_pend_hd & ~w_clr_hd) | (hard_drop & ~r_hd_d & w_acc);
            // The drop stays active across WAIT->REQ loops until it locks or times out.
            r_hd_act  <= w_clr_hd | (r_hd_act & (w_next != S_PLAY) & (w_next != S_LOCK));
        end
    end
`else
    assign w_hd_pend = 1'b0;
    assign w_hd_act  = 1'b0;
    assign w_clr_hd  = 1'b0;
`endif

    // Fixed priority: hard drop > rotate > left > right > down.
    assign w_clr_rot = w_play & ~w_hd_pend & r_pend_rot;
    assign w_clr_l   = w_play & ~w_hd_pend & ~r_pend_rot & r_pend_l;
    assign w_clr_r   = w_play & ~w_hd_pend & ~r_pend_rot & ~r_pend_l & r_pend_r;
    assign w_clr_dn  = w_play & ~w_hd_pend & ~r_pend_rot & ~r_pend_l & ~r_pend_r & r_pend_dn;
    assign w_issue   = w_clr_hd | w_clr_rot | w_clr_l | w_clr_r | w_clr_dn;
    assign w_op      = w_clr_rot ? (r_rot_dir ? OP_ROT_CW : OP_ROT_CCW) :
                       w_clr_l   ? OP_LEFT :
                       w_clr_r   ? OP_RIGHT : OP_DOWN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= OP_NONE;
            r_rot_d    <= 1'b0;
            r_l_d      <= 1'b0;
            r_r_d      <= 1'b0;
            r_dn_d     <= 1'b0;
            r_pend_rot <= 1'b0;
            r_pend_l   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_pend_dn  <= 1'b0;
            r_rot_dir  <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_state    <= w_next;
            r_op       <= w_issue ? w_op : r_op;
            r_rot_d    <= rotate;
            r_l_d      <= left;
            r_r_d      <= right;
            r_dn_d     <= ticker;
            // A new edge wins over a same-cycle clear.
            r_pend_rot <= (r_pend_rot & ~w_clr_rot) | w_rot_e;
            r_pend_l   <= (r_pend_l & ~w_clr_l) | (left & ~r_l_d & w_acc);
            r_pend_r   <= (r_pend_r & ~w_clr_r) | (right & ~r_r_d & w_acc);
            r_pend_dn  <= (r_pend_dn & ~w_clr_dn) | (ticker & ~r_dn_d & w_acc);
            r_rot_dir  <= w_rot_e ? rotate_direction : r_rot_dir;
            r_tmo      <= (r_state == S_WAIT) ? r_tmo + 1'b1 : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (start) w_next = S_CLEAR_ALL;
            S_CLEAR_ALL: w_next = S_SPAWN;
            S_SPAWN:     w_next = S_SPWAIT;
            S_SPWAIT:    if (spawn_done) w_next = spawn_collide ? S_GAME_OVER : S_PLAY;
            S_PLAY:      if (w_issue) w_next = S_REQ;
            S_REQ:       w_next = S_WAIT;
            S_WAIT: begin
                if (mv_done)
                    w_next = (r_op == OP_DOWN && !mv_ok) ? S_LOCK : (w_hd_act ? S_REQ : S_PLAY);
                else if (r_tmo == TW'(MV_TIMEOUT-1))
                    w_next = S_PLAY;
            end
            S_LOCK:      w_next = S_SCAN;
            S_SCAN:      w_next = w_row_full ? S_SHIFT : (w_done_scan ? S_SPAWN : S_SCAN);
            S_SHIFT:     w_next = S_SCAN;
            S_GAME_OVER: if (start) w_next = S_CLEAR_ALL;
            default:     w_next = S_IDLE;
        endcase
    end

    assign mv_valid  = (r_state == S_REQ);
    assign mv_op     = r_op;
    assign spawn_req = (r_state == S_SPAWN);
    assign game_over = (r_state == S_GAME_OVER);

    tetris_line_clear #(.LINES_W(LINES_W)) u_line_clear (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr_all    (r_state == S_CLEAR_ALL),
        .i_lock       (r_state == S_LOCK),
        .i_scan_dec   ((r_state == S_SCAN) & ~w_row_full),
        .i_shift      (r_state == S_SHIFT),
        .i_piece_mask (piece_mask),
        .o_board_q    (board_q),
        .o_lines      (lines),
        .o_row_is_full(w_row_full),
        .o_done_scan  (w_done_scan)
    );
endmodule

// File: tb/tb_tetris_game_ctrl.sv
// tb_tetris_game_ctrl: directed self-checking bench for tetris_game_ctrl.
module tb_tetris_game_ctrl;
    import tetris_pkg::*;
    localparam int N = ROWS*COLS;

    logic clk = 0, rst_n = 0, start = 0, rotate = 0, rotate_direction = 0;
    logic left = 0, right = 0, ticker = 0, mv_done = 0, mv_ok = 0;
    logic spawn_done = 1, spawn_collide = 0;
    logic [N-1:0] piece_mask = '0;
    logic mv_valid, spawn_req, game_over;
    logic [2:0] mv_op;
    logic [N-1:0] board_q;
    logic [15:0] lines;
    int n_chk = 0, n_fail = 0, vcnt = 0, scnt = 0;
`ifdef TETRIS_HARD_DROP_EN
    logic hard_drop = 0;
`endif

    tetris_game_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rotate(rotate),
        .rotate_direction(rotate_direction), .left(left), .right(right), .ticker(ticker),
`ifdef TETRIS_HARD_DROP_EN
        .hard_drop(hard_drop),
`endif
        .mv_valid(mv_valid), .mv_op(mv_op), .mv_done(mv_done), .mv_ok(mv_ok),
        .piece_mask(piece_mask), .spawn_req(spawn_req), .spawn_done(spawn_done),
        .spawn_collide(spawn_collide), .board_q(board_q), .lines(lines), .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mv_valid) vcnt++;
        if (spawn_req) scnt++;
    end

    task automatic tick(input int k = 1);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    // sel: 0 mv_valid, 1 spawn_req, 2 game_over; n = cycles waited or -1 if the bound expired
    task automatic wait_for(input int sel, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if ((sel == 0 && mv_valid) || (sel == 1 && spawn_req) || (sel == 2 && game_over)) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic respond(input logic ok);
        tick();
        mv_done = 1; mv_ok = ok;
        tick();
        mv_done = 0; mv_ok = 0;
    endtask

    task automatic test_reset();
        int s;
        rst_n = 0;
        tick(2);
        n_chk++; if (mv_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mv_valid: got %b expected 0", mv_valid); end
        n_chk++; if (mv_op !== 3'd0) begin n_fail++; $display("FAIL reset_mv_op: got %0d expected 0", mv_op); end
        n_chk++; if (spawn_req !== 1'b0) begin n_fail++; $display("FAIL reset_spawn_req: got %b expected 0", spawn_req); end
        n_chk++; if (board_q !== '0) begin n_fail++; $display("FAIL reset_board: got %h expected 0", board_q); end
        n_chk++; if (lines !== 16'd0) begin n_fail++; $display("FAIL reset_lines: got %0d expected 0", lines); end
        n_chk++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        rst_n = 1;
        s = scnt;
        tick(3);
        n_chk++; if (scnt - s !== 0) begin n_fail++; $display("FAIL idle_no_spawn: got %0d spawns expected 0", scnt - s); end
    endtask

    task automatic test_start();
        int s, n;
        s = scnt;
        start = 1;
        wait_for(1, 10, n);
        start = 0;
        n_chk++; if (n !== 2) begin n_fail++; $display("FAIL start_spawn_latency: got %0d expected 2", n); end
        tick(4);
        n_chk++; if (scnt - s !== 1) begin n_fail++; $display("FAIL start_spawn_count: got %0d expected 1", scnt - s); end
        n_chk++; if (board_q !== '0) begin n_fail++; $display("FAIL start_board: got %h expected 0", board_q); end
        n_chk++; if (lines !== 16'd0) begin n_fail++; $display("FAIL start_lines: got %0d expected 0", lines); end
        n_chk++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL start_game_over: got %b expected 0", game_over); end
    endtask

    task automatic test_two_buttons();
        int v, n;
        v = vcnt;
        left = 1; right = 1;
        wait_for(0, 10, n);
        n_chk++; if (n !== 2) begin n_fail++; $display("FAIL btn_latency: got %0d expected 2", n); end
        n_chk++; if (mv_op !== 3'd3) begin n_fail++; $display("FAIL btn_first_op: got %0d expected 3", mv_op); end
        respond(1);
        wait_for(0, 10, n);
        n_chk++; if (n !== 1) begin n_fail++; $display("FAIL btn_second_latency: got %0d expected 1", n); end
        n_chk++; if (mv_op !== 3'd4) begin n_fail++; $display("FAIL btn_second_op: got %0d expected 4", mv_op); end
        respond(1);
        left = 0; right = 0;
        tick(5);
        n_chk++; if (vcnt - v !== 2) begin n_fail++; $display("FAIL btn_valid_count: got %0d expected 2", vcnt - v); end
    endtask

    task automatic test_timeout();
        int n;
        rotate_direction = 1; rotate = 1; left = 1;
        wait_for(0, 10, n);
        n_chk++; if (mv_op !== 3'd1) begin n_fail++; $display("FAIL tmo_rot_cw_op: got %0d expected 1", mv_op); end
        wait_for(0, 30, n);
        n_chk++; if (n !== 17) begin n_fail++; $display("FAIL tmo_gap: got %0d expected 17", n); end
        n_chk++; if (mv_op !== 3'd3) begin n_fail++; $display("FAIL tmo_next_op: got %0d expected 3", mv_op); end
        respond(1);
        rotate = 0; left = 0;
        tick(2);
        rotate_direction = 0; rotate = 1;
        wait_for(0, 10, n);
        n_chk++; if (mv_op !== 3'd2) begin n_fail++; $display("FAIL rot_ccw_op: got %0d expected 2", mv_op); end
        respond(1);
        rotate = 0;
        tick(2);
    endtask

    task automatic test_line_clear();
        int n;
        logic [N-1:0] exp;
        piece_mask = '0;
        piece_mask[199:190] = '1;
        piece_mask[182] = 1'b1;
        piece_mask[175] = 1'b1;
        exp = '0;
        exp[192] = 1'b1;
        exp[185] = 1'b1;
        ticker = 1;
        wait_for(0, 10, n);
        n_chk++; if (mv_op !== 3'd5) begin n_fail++; $display("FAIL clr1_down_op: got %0d expected 5", mv_op); end
        respond(0);
        wait_for(1, 60, n);
        n_chk++; if (n !== 23) begin n_fail++; $display("FAIL clr1_cycles: got %0d expected 23", n); end
        n_chk++; if (board_q !== exp) begin n_fail++; $display("FAIL clr1_board: got %h expected %h", board_q, exp); end
        n_chk++; if (lines !== 16'd1) begin n_fail++; $display("FAIL clr1_lines: got %0d expected 1", lines); end
        ticker = 0; piece_mask = '0;
        tick(3);
    endtask

    task automatic test_tetris();
        int n;
        piece_mask = '0;
        piece_mask[199:160] = '1;
        ticker = 1;
        wait_for(0, 10, n);
        n_chk++; if (mv_op !== 3'd5) begin n_fail++; $display("FAIL clr4_down_op: got %0d expected 5", mv_op); end
        respond(0);
        wait_for(1, 60, n);
        n_chk++; if (n !== 29) begin n_fail++; $display("FAIL clr4_cycles: got %0d expected 29", n); end
        n_chk++; if (board_q !== '0) begin n_fail++; $display("FAIL clr4_board: got %h expected 0", board_q); end
        n_chk++; if (lines !== 16'd5) begin n_fail++; $display("FAIL clr4_lines: got %0d expected 5", lines); end
        ticker = 0; piece_mask = '0;
        tick(3);
    endtask

    task automatic test_reset_mid_shift();
        int n;
        logic [N-1:0] exp;
        exp = '0;
        exp[199:190] = '1;
        piece_mask = exp;
        ticker = 1;
        wait_for(0, 10, n);
        n_chk++; if (n !== 2) begin n_fail++; $display("FAIL rst_down_latency: got %0d expected 2", n); end
        respond(0);
        tick(2);
        n_chk++; if (board_q !== exp) begin n_fail++; $display("FAIL rst_locked_board: got %h expected %h", board_q, exp); end
        n_chk++; if (lines !== 16'd5) begin n_fail++; $display("FAIL rst_lines_before: got %0d expected 5", lines); end
        rst_n = 0;
        #1;
        n_chk++; if (board_q !== '0) begin n_fail++; $display("FAIL rst_async_board: got %h expected 0", board_q); end
        n_chk++; if (lines !== 16'd0) begin n_fail++; $display("FAIL rst_async_lines: got %0d expected 0", lines); end
        n_chk++; if (mv_op !== 3'd0) begin n_fail++; $display("FAIL rst_async_mv_op: got %0d expected 0", mv_op); end
        n_chk++; if ({mv_valid, spawn_req, game_over} !== 3'b000) begin n_fail++; $display("FAIL rst_async_strobes: got %b expected 000", {mv_valid, spawn_req, game_over}); end
        ticker = 0; piece_mask = '0;
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_game_over();
        int n, v;
        logic [N-1:0] exp;
        exp = '0;
        exp[0] = 1'b1;
        spawn_collide = 1;
        piece_mask = exp;
        ticker = 1;
        wait_for(0, 10, n);
        respond(0);
        wait_for(2, 60, n);
        n_chk++; if (n !== 23) begin n_fail++; $display("FAIL go_cycles: got %0d expected 23", n); end
        n_chk++; if (board_q !== exp) begin n_fail++; $display("FAIL go_board: got %h expected %h", board_q, exp); end
        ticker = 0;
        tick(2);
        v = vcnt;
        ticker = 1;
        tick(10);
        n_chk++; if (vcnt - v !== 0) begin n_fail++; $display("FAIL go_no_moves: got %0d expected 0", vcnt - v); end
        n_chk++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL go_held: got %b expected 1", game_over); end
        n_chk++; if (board_q !== exp) begin n_fail++; $display("FAIL go_board_held: got %h expected %h", board_q, exp); end
        spawn_collide = 0; ticker = 0; piece_mask = '0;
        start = 1;
        tick();
        start = 0;
        tick(3);
        n_chk++; if (board_q !== '0) begin n_fail++; $display("FAIL go_restart_board: got %h expected 0", board_q); end
        n_chk++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL go_restart_flag: got %b expected 0", game_over); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_two_buttons();
        test_timeout();
        test_line_clear();
        test_tetris();
        test_reset_mid_shift();
        test_start();
        test_game_over();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/tetris_game_ctrl.md
Name: tetris_game_ctrl

Overview:
- Sequencer for the Tetris next-board datapath.
- Edge-detects player buttons and gravity ticks, then issues one move request at a time to the datapath and waits for its legal/illegal verdict.
- On a failed gravity move, locks the active piece into the settled board, clears full rows one at a time, spawns the next piece and detects game over.
- Sits between the input debouncers/tick generator and the board datapath; owns the settled-board register.

Parameters:
ROWS, 20, board height; row 0 is the top row.
COLS, 10, board width; cell (r,c) is bit r*COLS+c.
LINES_W, 16, width of the cleared-lines counter.
MV_TIMEOUT, 15, cycles to wait for mv_done before abandoning a request.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; leaves IDLE or GAME_OVER
rotate  in  1  rotate button, level
rotate_direction  in  1  1 = cw, 0 = ccw; sampled at the rotate rising edge
left  in  1  move-left button, level
right  in  1  move-right button, level
ticker  in  1  gravity pulse, level
mv_valid  out  1  move request strobe, one cycle
mv_op  out  3  0 NONE, 1 ROT_CW, 2 ROT_CCW, 3 LEFT, 4 RIGHT, 5 DOWN
mv_done  in  1  datapath verdict strobe
mv_ok  in  1  with mv_done: 1 = move applied, 0 = collision
piece_mask  in  ROWS*COLS  cells occupied by the active piece
spawn_req  out  1  request a new piece, one cycle
spawn_done  in  1  spawn complete
spawn_collide  in  1  with spawn_done: new piece overlaps the board
board_q  out  ROWS*COLS  settled board
lines  out  LINES_W  total rows cleared, saturating
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, all pending flags 0, mv_op = NONE.
- Edge detection: rising edges of rotate, left, right and ticker set pend_rot, pend_l, pend_r and pend_dn. pend_rot also latches rotate_direction.
  - Flags are cleared only when their request is issued.
  - An edge in the same cycle as a clear leaves the flag set.
  - Edges outside PLAY, WAIT, REQ are discarded.
- States and transitions:
  - IDLE: start -> CLEAR_ALL.
  - CLEAR_ALL: board_q <= 0, lines <= 0 -> SPAWN.
  - SPAWN: pulse spawn_req, then -> SPWAIT.
  - SPWAIT: spawn_done & spawn_collide -> GAME_OVER; spawn_done & !spawn_collide -> PLAY.
  - PLAY: choose the highest-priority pending flag (rot > left > right > down). If one exists -> REQ, with mv_op registered and the flag cleared.
  - REQ: mv_valid = 1 for exactly this cycle -> WAIT.
  - WAIT:
    - mv_done -> PLAY, except DOWN with !mv_ok -> LOCK.
    - A non-DOWN !mv_ok is a silent no-op.
    - After MV_TIMEOUT cycles without mv_done -> PLAY, request dropped.
    - mv_done outside WAIT is ignored.
  - LOCK: board_q <= board_q | piece_mask; row index <= ROWS-1 -> SCAN.
  - SCAN: if row index is full (all COLS bits 1) -> SHIFT; else decrement. Leaving row 0 -> SPAWN.
  - SHIFT (one cycle):
    - Rows 1..index move down one; row 0 <= 0.
    - lines++, saturating at all-ones.
    - Index is unchanged, so the same row is rescanned -> SCAN.
  - GAME_OVER: game_over = 1; board_q is held; start -> CLEAR_ALL.
- Latency: a button edge reaches mv_valid 2 cycles later (flag set, PLAY decode, REQ) when the FSM is idle in PLAY.
- A four-row clear at the bottom takes 4 SHIFT cycles plus ROWS + 4 SCAN cycles.
- Asynchronous reset mid-operation returns to IDLE. There is no datapath handshake; the datapath must ignore a stale mv_done.

Optional Feature:
- TETRIS_HARD_DROP_EN: adds input hard_drop.
  - Its rising edge sets pend_hd, which has the highest priority.
  - Servicing it issues repeated DOWN requests, each REQ/WAIT, until !mv_ok, then LOCK.
  - Other edges stay pending until LOCK completes.
- Without the macro: port absent; behaviour exactly as above.

Decomposition:
- tetris_pkg:
  - constants ROWS and COLS;
  - typedef enum logic[2:0] move_op_t;
  - typedef enum FSM state_t;
  - function row_full(board, idx).
- One sub-module, tetris_line_clear: board_q register, merge, scan index, shift and lines counter, controlled by lock/scan/shift strobes from the FSM; reports done_scan and row_is_full.

Test Plan:
- Reset then start, spawn_done=1/collide=0 -> spawn_req pulse once; state PLAY; board_q=0, lines=0.
- left and right rising in the same cycle -> mv_op=3 first; after mv_done, mv_op=4 next; exactly 2 mv_valid pulses.
- ticker edge, mv_done=1/mv_ok=0, piece_mask fills bits 190..199 (row 19) with rows 17..18 having one cell each -> board_q row19 cleared; old rows 17..18 shifted to 18..19; lines=1; then spawn_req.
- Rows 16..19 full after lock -> 4 SHIFT cycles, lines=4, board_q rows 0..3 = 0.
- spawn_collide=1 -> game_over=1, further ticker edges produce no mv_valid; start -> board_q=0, lines=0.
- Move request with mv_done never returning -> return to PLAY after 15 cycles; next pending op issued; rst_n low mid-SHIFT -> all outputs 0 immediately.
